pc_upstream_merger: RTL and testbench

Parametrised N-input merger between core-side upstream sources and the PC upstream channel. It does the following:
- Round-robin arbitrates NUM_IN valid/ready inputs.
- Tags each word with a per-input code.
- Pads partial OK block transfers with NOP words, so host block reads never stall on a partially filled block.
- Sits between the core's upstream producers and the OK interface FIFO, in the okClk domain.

---
 rtl/pc_upstream_merger_pkg.sv | 19 +
 rtl/pc_upstream_merger_if.sv | 27 ++
 rtl/pc_upstream_merger_rr_arbiter.sv | 29 ++
 rtl/pc_upstream_merger.sv | 100 ++++++++++
 tb/tb_pc_upstream_merger.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_upstream_merger_pkg.sv
// Shared types and default widths for the PC upstream merger slice.
`timescale 1ns/1ps
package pc_upstream_pkg;

   localparam int NPCCODE_DFLT  = 8;
   localparam int NPCDATA_DFLT  = 24;
   localparam int NOP_CODE_DFLT = 64;

   typedef struct packed {
      logic [NPCCODE_DFLT-1:0] code;
      logic [NPCDATA_DFLT-1:0] data;
   } pc_word_t;

   typedef enum logic {
      FILL = 1'b0,
      PAD  = 1'b1
   } merger_state_t;

endpackage

// File: rtl/pc_upstream_merger_if.sv
// Upstream-producer and PC-channel handshake bundle; the merger uses the slave side.
`timescale 1ns/1ps
interface pc_upstream_merger_if
   import pc_upstream_pkg::*;
#(
   parameter int NUM_IN  = 4,
   parameter int NPCCODE = NPCCODE_DFLT,
   parameter int NPCDATA = NPCDATA_DFLT
);
   logic [NUM_IN-1:0]              in_valid;
   logic [NUM_IN-1:0]              in_ready;
   logic [NUM_IN-1:0][NPCDATA-1:0] in_data;
   logic [NUM_IN-1:0][NPCCODE-1:0] in_code;
   logic                           out_valid;
   logic                           out_ready;
   logic [NPCCODE+NPCDATA-1:0]     out_data;

   modport master (
      output in_valid, in_data, in_code, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_code, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pc_upstream_merger_rr_arbiter.sv
// Combinational round-robin priority rotate: first request at or above ptr, modulo N.
`timescale 1ns/1ps
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1,
   localparam int SW = PW + 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          grant_valid,
   output logic [PW-1:0] grant_idx
);
   logic [SW-1:0] sum;

   // Scan from the farthest offset down so the closest request to ptr wins last.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      sum         = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + SW'(k);
         if (sum >= SW'(N)) sum = sum - SW'(N);
         if (req[sum[PW-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = sum[PW-1:0];
         end
      end
   end
endmodule

// File: rtl/pc_upstream_merger.sv
// N-input round-robin merger onto the PC upstream channel; pads partial blocks with NOP words.
`timescale 1ns/1ps
module pc_upstream_merger
   import pc_upstream_pkg::*;
#(
   parameter int NUM_IN        = 4,
   parameter int NPCCODE       = NPCCODE_DFLT,
   parameter int NPCDATA       = NPCDATA_DFLT,
   parameter int NOP_CODE      = NOP_CODE_DFLT,
   parameter int BLOCK_WORDS   = 128,
   parameter int FLUSH_TIMEOUT = 1024
) (
   input  logic                           clk,
   input  logic                           reset,
   pc_upstream_merger_if.slave            bus,
   input  logic                           flush_req,
   output logic [$clog2(BLOCK_WORDS)-1:0] word_cnt,
   output logic [31:0]                    nop_count
);
   localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int WW = $clog2(BLOCK_WORDS);
   localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
   localparam int OW = NPCCODE + NPCDATA;

   merger_state_t state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] grant_idx;
   logic          grant_valid;
   logic [TW-1:0] idle_timer;
   logic          vld_p1;
   logic [OW-1:0] word_p1;
   logic          load;
   logic          flush_hit;
   logic          timeout_hit;
   logic          accept;
   logic          pad_load;

   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
      return (v == TW'(FLUSH_TIMEOUT)) ? v : v + TW'(1);
   endfunction

   function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
      return (idx == PW'(NUM_IN - 1)) ? '0 : idx + PW'(1);
   endfunction

   rr_arbiter #(.N(NUM_IN)) u_arb (
      .req         (bus.in_valid),
      .ptr         (rr_ptr),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // An explicit flush beats a same-cycle grant; a timeout only fires if nothing is granted.
   always_comb begin
      load        = !vld_p1 || bus.out_ready;
      flush_hit   = (state == FILL) && (word_cnt != '0) && flush_req;
      timeout_hit = (state == FILL) && (word_cnt != '0) &&
                    (idle_timer == TW'(FLUSH_TIMEOUT)) && !(load && grant_valid);
      accept      = reset && (state == FILL) && load && grant_valid && !flush_hit;
      pad_load    = (state == PAD) && load;
      bus.in_ready = '0;
      if (accept) bus.in_ready[grant_idx] = 1'b1;
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_data  = word_p1;

   // p1: output register stage
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= FILL;
         rr_ptr     <= '0;
         idle_timer <= '0;
         vld_p1     <= 1'b0;
         word_p1    <= '0;
         word_cnt   <= '0;
         nop_count  <= '0;
      end else begin
         if (accept) begin
            vld_p1   <= 1'b1;
            word_p1  <= {bus.in_code[grant_idx], bus.in_data[grant_idx]};
            rr_ptr   <= rr_next(grant_idx);
            word_cnt <= word_cnt + WW'(1);
         end else if (pad_load) begin
            vld_p1    <= 1'b1;
            word_p1   <= {NPCCODE'(NOP_CODE), NPCDATA'(0)};
            nop_count <= nop_count + 32'd1;
            word_cnt  <= word_cnt + WW'(1);
            if (word_cnt == WW'(BLOCK_WORDS - 1)) state <= FILL;
         end else if (load) begin
            vld_p1 <= 1'b0;
         end

         if (flush_hit || timeout_hit) state <= PAD;

         if (accept || (word_cnt == '0) || (state == PAD)) idle_timer <= '0;
         else idle_timer <= sat_inc(idle_timer);
      end
   end
endmodule

// File: tb/tb_pc_upstream_merger.sv
// Directed bench for pc_upstream_merger with NUM_IN=4, BLOCK_WORDS=8, FLUSH_TIMEOUT=16.
`timescale 1ns/1ps
module tb_pc_upstream_merger;
   import pc_upstream_pkg::*;

   localparam int          NUM_IN   = 4;
   localparam logic [31:0] NOP_WORD = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush_req = 1'b0;
   logic [2:0]  word_cnt;
   logic [31:0] nop_count;
   int          n_tests = 0;
   int          n_fail = 0;

   pc_upstream_merger_if #(.NUM_IN(4), .NPCCODE(8), .NPCDATA(24)) bus ();

   pc_upstream_merger #(
      .NUM_IN(4), .NPCCODE(8), .NPCDATA(24), .NOP_CODE(64),
      .BLOCK_WORDS(8), .FLUSH_TIMEOUT(16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .flush_req (flush_req),
      .word_cnt  (word_cnt),
      .nop_count (nop_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mkword(input int code, input int data);
      pc_word_t w;
      w.code = 8'(code);
      w.data = 24'(data);
      return w;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      bus.in_valid = '0;
      flush_req = 1'b0;
      bus.out_ready = 1'b1;
      tick;
      tick;
      reset = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      flush_req = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid = '1;
      for (int i = 0; i < NUM_IN; i++) bus.in_data[i] = 24'h0;
      tick;
      tick;
      @(negedge clk);
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_tests++;
      if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
      n_tests++;
      if (word_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
      n_tests++;
      if (nop_count !== 32'd0) begin n_fail++; $display("FAIL reset_nop_count: got %0d want 0", nop_count); end
      n_tests++;
      if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready); end
      bus.in_valid = '0;
      tick;
      reset = 1'b1;
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_rdy;
      for (int i = 0; i < NUM_IN; i++) bus.in_data[i] = 24'(16 * i);
      bus.in_valid = '1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp_rdy = 4'(1 << (k % 4));
         n_tests++;
         if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_in_ready[%0d]: got %b want %b", k, bus.in_ready, exp_rdy); end
         if (k > 0) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== mkword((k - 1) % 4 + 1, 16 * ((k - 1) % 4))) begin
               n_fail++;
               $display("FAIL rr_out[%0d]: got v=%b %h want %h", k - 1, bus.out_valid, bus.out_data, mkword((k - 1) % 4 + 1, 16 * ((k - 1) % 4)));
            end
         end
         tick;
      end
      bus.in_valid = '0;
      @(negedge clk);
      n_tests++;
      if (bus.out_data !== mkword(4, 'h30)) begin n_fail++; $display("FAIL rr_out[7]: got %h want %h", bus.out_data, mkword(4, 'h30)); end
      n_tests++;
      if (word_cnt !== 3'd0) begin n_fail++; $display("FAIL rr_word_cnt: got %0d want 0", word_cnt); end
      n_tests++;
      if (nop_count !== 32'd0) begin n_fail++; $display("FAIL rr_nop_count: got %0d want 0", nop_count); end
      tick;
   endtask

   task automatic test_timeout;
      int          q_idx[$];
      logic [31:0] q_word[$];
      do_reset;
      for (int n = 0; n < 40; n++) begin
         bus.in_valid = (n < 3) ? 4'b0100 : 4'b0000;
         bus.in_data[2] = 24'('hA00 + n);
         @(negedge clk);
         if (n < 3) begin
            n_tests++;
            if (bus.in_ready !== 4'b0100) begin n_fail++; $display("FAIL to_in_ready[%0d]: got %b want 0100", n, bus.in_ready); end
         end
         if (bus.out_valid) begin q_idx.push_back(n - 1); q_word.push_back(bus.out_data); end
         tick;
      end
      n_tests++;
      if (q_word.size() != 8) begin n_fail++; $display("FAIL to_word_total: got %0d want 8", q_word.size()); end
      if (q_word.size() == 8) begin
         for (int j = 0; j < 3; j++) begin
            n_tests++;
            if (q_word[j] !== mkword(3, 'hA00 + j)) begin n_fail++; $display("FAIL to_data[%0d]: got %h want %h", j, q_word[j], mkword(3, 'hA00 + j)); end
         end
         for (int j = 3; j < 8; j++) begin
            n_tests++;
            if (q_word[j] !== NOP_WORD) begin n_fail++; $display("FAIL to_nop[%0d]: got %h want %h", j, q_word[j], NOP_WORD); end
         end
         n_tests++;
         if (q_idx[3] - q_idx[2] != 18) begin n_fail++; $display("FAIL to_gap: got %0d want 18", q_idx[3] - q_idx[2]); end
         n_tests++;
         if (q_idx[7] - q_idx[3] != 4) begin n_fail++; $display("FAIL to_nop_span: got %0d want 4", q_idx[7] - q_idx[3]); end
      end
      n_tests++;
      if (word_cnt !== 3'd0) begin n_fail++; $display("FAIL to_word_cnt: got %0d want 0", word_cnt); end
      n_tests++;
      if (nop_count !== 32'd5) begin n_fail++; $display("FAIL to_nop_count: got %0d want 5", nop_count); end
   endtask

   task automatic test_flush;
      int          q_idx[$];
      logic [31:0] q_word[$];
      do_reset;
      bus.in_data[0] = 24'h123456;
      bus.in_data[1] = 24'h00BEEF;
      for (int n = 0; n < 14; n++) begin
         bus.in_valid = (n == 0) ? 4'b0001 : ((n >= 2 && n <= 9) ? 4'b0010 : 4'b0000);
         flush_req = (n == 1 || n == 4);
         @(negedge clk);
         if (n >= 2 && n <= 8) begin
            n_tests++;
            if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL pad_in_ready[%0d]: got %b want 0000", n, bus.in_ready); end
         end
         if (n == 9) begin
            n_tests++;
            if (bus.in_ready !== 4'b0010) begin n_fail++; $display("FAIL post_pad_in_ready: got %b want 0010", bus.in_ready); end
         end
         if (bus.out_valid) begin q_idx.push_back(n - 1); q_word.push_back(bus.out_data); end
         tick;
      end
      flush_req = 1'b0;
      n_tests++;
      if (q_word.size() != 9) begin n_fail++; $display("FAIL fl_word_total: got %0d want 9", q_word.size()); end
      if (q_word.size() == 9) begin
         n_tests++;
         if (q_word[0] !== mkword(1, 'h123456) || q_idx[0] != 0) begin n_fail++; $display("FAIL fl_first: got %h@%0d want %h@0", q_word[0], q_idx[0], mkword(1, 'h123456)); end
         for (int j = 1; j < 8; j++) begin
            n_tests++;
            if (q_word[j] !== NOP_WORD || q_idx[j] != j + 1) begin n_fail++; $display("FAIL fl_nop[%0d]: got %h@%0d want %h@%0d", j, q_word[j], q_idx[j], NOP_WORD, j + 1); end
         end
         n_tests++;
         if (q_word[8] !== mkword(2, 'hBEEF) || q_idx[8] != 9) begin n_fail++; $display("FAIL fl_resume: got %h@%0d want %h@9", q_word[8], q_idx[8], mkword(2, 'hBEEF)); end
      end
      n_tests++;
      if (nop_count !== 32'd7) begin n_fail++; $display("FAIL fl_nop_count: got %0d want 7", nop_count); end
      n_tests++;
      if (word_cnt !== 3'd1) begin n_fail++; $display("FAIL fl_word_cnt: got %0d want 1", word_cnt); end
   endtask

   task automatic test_flush_empty;
      int seen;
      do_reset;
      bus.in_data[0] = 24'h000777;
      flush_req = 1'b1;
      tick;
      flush_req = 1'b0;
      seen = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
         tick;
      end
      n_tests++;
      if (seen != 0) begin n_fail++; $display("FAIL fe_no_output: got %0d words want 0", seen); end
      n_tests++;
      if (nop_count !== 32'd0) begin n_fail++; $display("FAIL fe_nop_count: got %0d want 0", nop_count); end
      n_tests++;
      if (word_cnt !== 3'd0) begin n_fail++; $display("FAIL fe_word_cnt: got %0d want 0", word_cnt); end
      flush_req = 1'b1;
      bus.in_valid = 4'b0001;
      @(negedge clk);
      n_tests++;
      if (bus.in_ready !== 4'b0001) begin n_fail++; $display("FAIL fe_accept_with_flush: got %b want 0001", bus.in_ready); end
      tick;
      flush_req = 1'b0;
      bus.in_valid = '0;
      @(negedge clk);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== mkword(1, 'h777)) begin n_fail++; $display("FAIL fe_word: got v=%b %h want %h", bus.out_valid, bus.out_data, mkword(1, 'h777)); end
      n_tests++;
      if (word_cnt !== 3'd1) begin n_fail++; $display("FAIL fe_word_cnt1: got %0d want 1", word_cnt); end
      tick;
      seen = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
         tick;
      end
      n_tests++;
      if (seen != 0) begin n_fail++; $display("FAIL fe_not_remembered: got %0d words want 0", seen); end
      n_tests++;
      if (nop_count !== 32'd0) begin n_fail++; $display("FAIL fe_nop_count2: got %0d want 0", nop_count); end
   endtask

   task automatic test_backpressure;
      logic [31:0] consumed[$];
      logic [3:0]  exp_rdy;
      do_reset;
      for (int i = 0; i < NUM_IN; i++) bus.in_data[i] = 24'(16 * i);
      for (int n = 0; n < 12; n++) begin
         bus.in_valid = (n <= 10) ? 4'b1111 : 4'b0000;
         bus.out_ready = !(n >= 2 && n <= 6);
         @(negedge clk);
         if (n >= 2 && n <= 6) begin
            n_tests++;
            if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", n, bus.in_ready); end
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== mkword(2, 'h10)) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b %h want %h", n, bus.out_valid, bus.out_data, mkword(2, 'h10)); end
         end
         if (n >= 7 && n <= 10) begin
            exp_rdy = 4'(1 << ((n - 5) % 4));
            n_tests++;
            if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_resume_rdy[%0d]: got %b want %b", n, bus.in_ready, exp_rdy); end
         end
         if (bus.out_valid && bus.out_ready) consumed.push_back(bus.out_data);
         tick;
      end
      bus.out_ready = 1'b1;
      n_tests++;
      if (consumed.size() != 6) begin n_fail++; $display("FAIL bp_consumed_total: got %0d want 6", consumed.size()); end
      if (consumed.size() == 6) begin
         for (int j = 0; j < 6; j++) begin
            n_tests++;
            if (consumed[j] !== mkword(j % 4 + 1, 16 * (j % 4))) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", j, consumed[j], mkword(j % 4 + 1, 16 * (j % 4))); end
         end
      end
   endtask

   task automatic test_reset_mid_pad;
      do_reset;
      bus.in_data[2] = 24'h0000AA;
      for (int n = 0; n < 5; n++) begin
         bus.in_valid = (n == 0) ? 4'b0100 : 4'b0000;
         flush_req = (n == 1);
         @(negedge clk);
         tick;
      end
      flush_req = 1'b0;
      reset = 1'b0;
      bus.in_valid = '1;
      @(negedge clk);
      n_tests++;
      if (nop_count !== 32'd3) begin n_fail++; $display("FAIL mp_nop_before: got %0d want 3", nop_count); end
      n_tests++;
      if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL mp_rdy_in_reset: got %b want 0000", bus.in_ready); end
      tick;
      @(negedge clk);
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mp_out_valid: got %b want 0", bus.out_valid); end
      n_tests++;
      if (word_cnt !== 3'd0) begin n_fail++; $display("FAIL mp_word_cnt: got %0d want 0", word_cnt); end
      n_tests++;
      if (nop_count !== 32'd0) begin n_fail++; $display("FAIL mp_nop_count: got %0d want 0", nop_count); end
      tick;
      reset = 1'b1;
      for (int i = 0; i < NUM_IN; i++) bus.in_data[i] = 24'(16 * i);
      @(negedge clk);
      n_tests++;
      if (bus.in_ready !== 4'b0001) begin n_fail++; $display("FAIL mp_first_grant: got %b want 0001", bus.in_ready); end
      tick;
      @(negedge clk);
      n_tests++;
      if (bus.out_data !== mkword(1, 0)) begin n_fail++; $display("FAIL mp_first_word: got %h want %h", bus.out_data, mkword(1, 0)); end
      bus.in_valid = '0;
      tick;
   endtask

   initial begin
      bus.in_valid = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
         bus.in_code[i] = 8'(i + 1);
         bus.in_data[i] = 24'h0;
      end
      test_reset;
      test_round_robin;
      test_timeout;
      test_flush;
      test_flush_empty;
      test_backpressure;
      test_reset_mid_pad;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
